// File: rtl/otter_pipe_pkg.sv
// Shared OTTER pipeline types: opcodes, PC source encoding, forwarding selects, hazard FSM states.
package otter_pipe_pkg;

  typedef enum logic [6:0] {
    OpLui    = 7'b0110111,
    OpAuipc  = 7'b0010111,
    OpJal    = 7'b1101111,
    OpJalr   = 7'b1100111,
    OpBranch = 7'b1100011,
    OpLoad   = 7'b0000011,
    OpStore  = 7'b0100011,
    OpImm    = 7'b0010011,
    OpReg    = 7'b0110011,
    OpSys    = 7'b1110011
  } opcode_t;

  typedef enum logic [3:0] {
    PcSeq    = 4'd0,
    PcJalr   = 4'd1,
    PcBranch = 4'd2,
    PcJal    = 4'd3,
    PcMtvec  = 4'd4,
    PcMepc   = 4'd5
  } pc_src_t;

  typedef enum logic [1:0] {
    FwdRf  = 2'd0,
    FwdMem = 2'd1,
    FwdWb  = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    StRun,
    StIntDrain,
    StIntRedir
  } hz_state_t;

  // x0 is hardwired to zero, so it never produces a dependency.
  function automatic logic src_hit(input logic [4:0] src, input logic used,
                                   input logic [4:0] rd, input logic wr);
    return used && wr && (src != 5'd0) && (src == rd);
  endfunction

endpackage

// File: rtl/otter_fwd_unit.sv
// EX operand forwarding select: MEM result beats WB write data; x0 is never forwarded.
module otter_fwd_unit
  import otter_pipe_pkg::*;
(
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_regwrite_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_regwrite_i,
  output fwd_sel_t   fwd_a_o,
  output fwd_sel_t   fwd_b_o
);

  function automatic fwd_sel_t pick(input logic [4:0] src, input logic [4:0] mem_rd,
                                    input logic mem_wr, input logic [4:0] wb_rd,
                                    input logic wb_wr);
    if (src_hit(src, 1'b1, mem_rd, mem_wr)) begin
      return FwdMem;
    end else if (src_hit(src, 1'b1, wb_rd, wb_wr)) begin
      return FwdWb;
    end
    return FwdRf;
  endfunction

  always_comb begin
    fwd_a_o = pick(ex_rs1_i, mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i);
    fwd_b_o = pick(ex_rs2_i, mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i);
  end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// OTTER pipeline sequencer: stalls, flushes, forwarding selects and interrupt drain/redirect.
// Define OTTER_HZ_FWD_EN to enable forwarding; otherwise every RAW on EX/MEM stalls.
module otter_hazard_ctrl
  import otter_pipe_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] ID_RS1,
  input  logic [4:0] ID_RS2,
  input  logic       ID_RS1_USED,
  input  logic       ID_RS2_USED,
  input  logic [4:0] EX_RS1,
  input  logic [4:0] EX_RS2,
  input  logic [4:0] EX_RD,
  input  logic       EX_REGWRITE,
  input  logic       EX_MEMREAD2,
  input  logic       EX_VALID,
  input  logic [3:0] EX_PCSOURCE,
  input  logic [4:0] MEM_RD,
  input  logic       MEM_REGWRITE,
  input  logic [4:0] WB_RD,
  input  logic       WB_REGWRITE,
  input  logic       DMEM_BUSY,
  input  logic       INTR,
  input  logic       CSR_MIE,
  output logic       PC_WRITE,
  output logic       IFID_WRITE,
  output logic       IDEX_WRITE,
  output logic       EXMEM_WRITE,
  output logic       MEMWB_WRITE,
  output logic       IFID_FLUSH,
  output logic       IDEX_FLUSH,
  output logic [1:0] FWD_A_SEL,
  output logic [1:0] FWD_B_SEL,
  output logic       INT_TAKEN
);

  localparam int unsigned CntW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] DrainMax = CntW'(DRAIN_CYCLES);

  hz_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rst_q;
  logic            in_rst;
  logic            ex_redirect;
  logic            stall;
  fwd_sel_t        fwd_a, fwd_b;

  // Reset behaviour persists for one cycle after RST falls so the front end restarts clean.
  assign in_rst      = RST || rst_q;
  assign ex_redirect = EX_VALID && (EX_PCSOURCE != PcSeq);

`ifdef OTTER_HZ_FWD_EN
  logic ld_wr;
  assign ld_wr = EX_VALID && EX_MEMREAD2 && EX_REGWRITE;
  assign stall = src_hit(ID_RS1, ID_RS1_USED, EX_RD, ld_wr) ||
                 src_hit(ID_RS2, ID_RS2_USED, EX_RD, ld_wr);

  otter_fwd_unit u_fwd (
    .ex_rs1_i       (EX_RS1),
    .ex_rs2_i       (EX_RS2),
    .mem_rd_i       (MEM_RD),
    .mem_regwrite_i (MEM_REGWRITE),
    .wb_rd_i        (WB_RD),
    .wb_regwrite_i  (WB_REGWRITE),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b)
  );
`else
  logic ex_wr;
  logic unused_nofwd;
  assign ex_wr = EX_VALID && EX_REGWRITE;
  // WB needs no check: the register file writes before it reads.
  assign stall = src_hit(ID_RS1, ID_RS1_USED, EX_RD, ex_wr) ||
                 src_hit(ID_RS2, ID_RS2_USED, EX_RD, ex_wr) ||
                 src_hit(ID_RS1, ID_RS1_USED, MEM_RD, MEM_REGWRITE) ||
                 src_hit(ID_RS2, ID_RS2_USED, MEM_RD, MEM_REGWRITE);
  assign fwd_a = FwdRf;
  assign fwd_b = FwdRf;
  assign unused_nofwd = ^{EX_RS1, EX_RS2, EX_MEMREAD2, WB_RD, WB_REGWRITE};
`endif

  assign FWD_A_SEL = in_rst ? 2'd0 : fwd_a;
  assign FWD_B_SEL = in_rst ? 2'd0 : fwd_b;
  assign INT_TAKEN = (state_q == StIntRedir) && !in_rst;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    PC_WRITE    = 1'b1;
    IFID_WRITE  = 1'b1;
    IDEX_WRITE  = 1'b1;
    EXMEM_WRITE = 1'b1;
    MEMWB_WRITE = 1'b1;
    IFID_FLUSH  = 1'b0;
    IDEX_FLUSH  = 1'b0;
    if (in_rst) begin
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
      state_d    = StRun;
      cnt_d      = '0;
    end else if (DMEM_BUSY) begin
      PC_WRITE    = 1'b0;
      IFID_WRITE  = 1'b0;
      IDEX_WRITE  = 1'b0;
      EXMEM_WRITE = 1'b0;
      MEMWB_WRITE = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ex_redirect) begin
            IFID_FLUSH = 1'b1;
            IDEX_FLUSH = 1'b1;
          end else begin
            if (stall) begin
              PC_WRITE   = 1'b0;
              IFID_WRITE = 1'b0;
              IDEX_FLUSH = 1'b1;
            end
            if (INTR && CSR_MIE) begin
              state_d = StIntDrain;
              cnt_d   = '0;
            end
          end
        end
        StIntDrain: begin
          PC_WRITE   = 1'b0;
          IFID_FLUSH = 1'b1;
          if (ex_redirect) begin
            PC_WRITE   = 1'b1;
            IDEX_FLUSH = 1'b1;
            cnt_d      = '0;
          end else begin
            // A stalled ID instruction is held rather than flushed so it is not lost.
            if (stall) begin
              IFID_WRITE = 1'b0;
              IFID_FLUSH = 1'b0;
              IDEX_FLUSH = 1'b1;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DrainMax) begin
              state_d = StIntRedir;
            end
          end
        end
        StIntRedir: begin
          IFID_FLUSH = 1'b1;
          IDEX_FLUSH = 1'b1;
          state_d    = StRun;
          cnt_d      = '0;
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StRun;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Scoreboard bench for otter_hazard_ctrl; expectations are queued per cycle and checked mid-cycle.
module tb_otter_hazard_ctrl;

`ifdef OTTER_HZ_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  // {PC, IFID, IDEX, EXMEM, MEMWB write, IFID flush, IDEX flush}
  localparam logic [6:0] Norm  = 7'b11111_00;
  localparam logic [6:0] Rsto  = 7'b11111_11;
  localparam logic [6:0] Busy  = 7'b00000_00;
  localparam logic [6:0] Stall = 7'b00111_01;
  localparam logic [6:0] Redir = 7'b11111_11;
  localparam logic [6:0] Drain = 7'b01111_10;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] ID_RS1, ID_RS2, EX_RS1, EX_RS2, EX_RD, MEM_RD, WB_RD;
  logic       ID_RS1_USED, ID_RS2_USED, EX_REGWRITE, EX_MEMREAD2, EX_VALID;
  logic [3:0] EX_PCSOURCE;
  logic       MEM_REGWRITE, WB_REGWRITE, DMEM_BUSY, INTR, CSR_MIE;
  logic       PC_WRITE, IFID_WRITE, IDEX_WRITE, EXMEM_WRITE, MEMWB_WRITE;
  logic       IFID_FLUSH, IDEX_FLUSH, INT_TAKEN;
  logic [1:0] FWD_A_SEL, FWD_B_SEL;

  typedef struct {
    string      tag;
    logic [6:0] wf;
    logic [3:0] fwd;
    logic       it;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  otter_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ID_RS1       (ID_RS1),
    .ID_RS2       (ID_RS2),
    .ID_RS1_USED  (ID_RS1_USED),
    .ID_RS2_USED  (ID_RS2_USED),
    .EX_RS1       (EX_RS1),
    .EX_RS2       (EX_RS2),
    .EX_RD        (EX_RD),
    .EX_REGWRITE  (EX_REGWRITE),
    .EX_MEMREAD2  (EX_MEMREAD2),
    .EX_VALID     (EX_VALID),
    .EX_PCSOURCE  (EX_PCSOURCE),
    .MEM_RD       (MEM_RD),
    .MEM_REGWRITE (MEM_REGWRITE),
    .WB_RD        (WB_RD),
    .WB_REGWRITE  (WB_REGWRITE),
    .DMEM_BUSY    (DMEM_BUSY),
    .INTR         (INTR),
    .CSR_MIE      (CSR_MIE),
    .PC_WRITE     (PC_WRITE),
    .IFID_WRITE   (IFID_WRITE),
    .IDEX_WRITE   (IDEX_WRITE),
    .EXMEM_WRITE  (EXMEM_WRITE),
    .MEMWB_WRITE  (MEMWB_WRITE),
    .IFID_FLUSH   (IFID_FLUSH),
    .IDEX_FLUSH   (IDEX_FLUSH),
    .FWD_A_SEL    (FWD_A_SEL),
    .FWD_B_SEL    (FWD_B_SEL),
    .INT_TAKEN    (INT_TAKEN)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ID_RS1 = '0; ID_RS2 = '0; ID_RS1_USED = 1'b0; ID_RS2_USED = 1'b0;
    EX_RS1 = '0; EX_RS2 = '0; EX_RD = '0;
    EX_REGWRITE = 1'b0; EX_MEMREAD2 = 1'b0; EX_VALID = 1'b0; EX_PCSOURCE = '0;
    MEM_RD = '0; MEM_REGWRITE = 1'b0; WB_RD = '0; WB_REGWRITE = 1'b0;
    DMEM_BUSY = 1'b0; INTR = 1'b0; CSR_MIE = 1'b0;
  endtask

  // lw x5 in EX, add x6,x5,x1 in ID
  task automatic load_use();
    EX_VALID = 1'b1; EX_MEMREAD2 = 1'b1; EX_REGWRITE = 1'b1; EX_RD = 5'd5;
    ID_RS1 = 5'd5; ID_RS1_USED = 1'b1; ID_RS2 = 5'd1; ID_RS2_USED = 1'b1;
  endtask

  task automatic cyc(input string tag, input logic [6:0] wf, input logic [3:0] fwd,
                     input logic it);
    exp_t e;
    e.tag = tag; e.wf = wf; e.fwd = fwd; e.it = it;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check_eq({e.tag, ".wr"},
               {3'b0, PC_WRITE, IFID_WRITE, IDEX_WRITE, EXMEM_WRITE, MEMWB_WRITE},
               {3'b0, e.wf[6:2]});
      check_eq({e.tag, ".fl"}, {6'b0, IFID_FLUSH, IDEX_FLUSH}, {6'b0, e.wf[1:0]});
      check_eq({e.tag, ".fwd"}, {4'b0, FWD_A_SEL, FWD_B_SEL}, {4'b0, e.fwd});
      check_eq({e.tag, ".int"}, {7'b0, INT_TAKEN}, {7'b0, e.it});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clr();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    // Reset and the cycle after it override any hazard inputs.
    cyc("rst0", Rsto, 4'b0, 1'b0);
    cyc("rst1", Rsto, 4'b0, 1'b0);
    RST = 1'b0;
    load_use();
    EX_RS1 = 5'd5; MEM_RD = 5'd5; MEM_REGWRITE = 1'b1;
    cyc("rst_post", Rsto, 4'b0, 1'b0);
    clr();
    cyc("idle", Norm, 4'b0, 1'b0);

    // Load-use: one stall, then forward from WB once the load reaches it.
    load_use();
    cyc("lu_stall", Stall, 4'b0, 1'b0);
    EX_VALID = 1'b0; EX_MEMREAD2 = 1'b0; EX_REGWRITE = 1'b0; EX_RD = '0;
    MEM_RD = 5'd5; MEM_REGWRITE = 1'b1;
    cyc("lu_next", FwdEn ? Norm : Stall, 4'b0, 1'b0);
    clr();
    WB_RD = 5'd5; WB_REGWRITE = 1'b1;
    EX_VALID = 1'b1; EX_REGWRITE = 1'b1; EX_RD = 5'd6; EX_RS1 = 5'd5; EX_RS2 = 5'd1;
    cyc("lu_fwd", Norm, FwdEn ? 4'b10_00 : 4'b0, 1'b0);

    // Forwarding priority and x0.
    clr();
    EX_VALID = 1'b1; EX_RS1 = 5'd3; EX_RS2 = 5'd4;
    MEM_RD = 5'd3; MEM_REGWRITE = 1'b1; WB_RD = 5'd3; WB_REGWRITE = 1'b1;
    cyc("mem_wins", Norm, FwdEn ? 4'b01_00 : 4'b0, 1'b0);
    WB_RD = 5'd4;
    cyc("fwd_ab", Norm, FwdEn ? 4'b01_10 : 4'b0, 1'b0);
    clr();
    EX_VALID = 1'b1; EX_REGWRITE = 1'b1; EX_MEMREAD2 = 1'b1; EX_RD = '0;
    ID_RS1_USED = 1'b1; ID_RS2_USED = 1'b1;
    MEM_REGWRITE = 1'b1; WB_REGWRITE = 1'b1;
    cyc("x0", Norm, 4'b0, 1'b0);

    // ALU RAW: stalls twice without forwarding, never with it.
    clr();
    EX_VALID = 1'b1; EX_REGWRITE = 1'b1; EX_RD = 5'd3; ID_RS2 = 5'd3; ID_RS2_USED = 1'b1;
    cyc("alu_ex", FwdEn ? Norm : Stall, 4'b0, 1'b0);
    EX_VALID = 1'b0; EX_REGWRITE = 1'b0; EX_RD = '0; MEM_RD = 5'd3; MEM_REGWRITE = 1'b1;
    cyc("alu_mem", FwdEn ? Norm : Stall, 4'b0, 1'b0);
    MEM_RD = '0; MEM_REGWRITE = 1'b0; WB_RD = 5'd3; WB_REGWRITE = 1'b1;
    cyc("alu_wb", Norm, 4'b0, 1'b0);

    // Source register present but unused.
    clr();
    load_use();
    ID_RS1_USED = 1'b0;
    cyc("unused_src", Norm, 4'b0, 1'b0);

    // Redirect overrides the stall.
    clr();
    load_use();
    EX_PCSOURCE = 4'd2;
    cyc("redir_vs_stall", Redir, 4'b0, 1'b0);

    // Busy freezes everything, then the stall happens exactly once.
    clr();
    load_use();
    DMEM_BUSY = 1'b1;
    for (int i = 0; i < 4; i++) cyc($sformatf("busy%0d", i), Busy, 4'b0, 1'b0);
    DMEM_BUSY = 1'b0;
    cyc("busy_stall", Stall, 4'b0, 1'b0);
    clr();
    cyc("busy_after", Norm, 4'b0, 1'b0);

    // Interrupt: entry is latched; taken on the fourth cycle after sampling.
    INTR = 1'b1; CSR_MIE = 1'b1;
    cyc("int_entry", Norm, 4'b0, 1'b0);
    clr();
    for (int i = 0; i < 3; i++) cyc($sformatf("int_drain%0d", i), Drain, 4'b0, 1'b0);
    cyc("int_taken", Redir, 4'b0, 1'b1);
    cyc("int_done", Norm, 4'b0, 1'b0);

    // A jal in EX during the drain restarts the count.
    INTR = 1'b1; CSR_MIE = 1'b1;
    cyc("jal_entry", Norm, 4'b0, 1'b0);
    clr();
    cyc("jal_drain0", Drain, 4'b0, 1'b0);
    EX_VALID = 1'b1; EX_PCSOURCE = 4'd3;
    cyc("jal_redir", Redir, 4'b0, 1'b0);
    clr();
    for (int i = 0; i < 3; i++) cyc($sformatf("jal_drain%0d", i + 1), Drain, 4'b0, 1'b0);
    cyc("jal_taken", Redir, 4'b0, 1'b1);
    cyc("jal_done", Norm, 4'b0, 1'b0);

    // Busy holds the drain counter and keeps INT_TAKEN up.
    INTR = 1'b1; CSR_MIE = 1'b1;
    cyc("bi_entry", Norm, 4'b0, 1'b0);
    clr();
    cyc("bi_drain0", Drain, 4'b0, 1'b0);
    DMEM_BUSY = 1'b1;
    cyc("bi_busy_drain", Busy, 4'b0, 1'b0);
    DMEM_BUSY = 1'b0;
    cyc("bi_drain1", Drain, 4'b0, 1'b0);
    cyc("bi_drain2", Drain, 4'b0, 1'b0);
    DMEM_BUSY = 1'b1;
    cyc("bi_taken_busy", Busy, 4'b0, 1'b1);
    DMEM_BUSY = 1'b0;
    cyc("bi_taken", Redir, 4'b0, 1'b1);
    cyc("bi_done", Norm, 4'b0, 1'b0);

    // Masked interrupt never enters.
    INTR = 1'b1; CSR_MIE = 1'b0;
    for (int i = 0; i < 5; i++) cyc($sformatf("masked%0d", i), Norm, 4'b0, 1'b0);

    // Redirect in the request cycle blocks entry.
    clr();
    INTR = 1'b1; CSR_MIE = 1'b1; EX_VALID = 1'b1; EX_PCSOURCE = 4'd1;
    cyc("redir_blocks", Redir, 4'b0, 1'b0);
    clr();
    for (int i = 0; i < 5; i++) cyc($sformatf("no_entry%0d", i), Norm, 4'b0, 1'b0);

    // Reset mid-drain drops the interrupt.
    INTR = 1'b1; CSR_MIE = 1'b1;
    cyc("rd_entry", Norm, 4'b0, 1'b0);
    clr();
    cyc("rd_drain0", Drain, 4'b0, 1'b0);
    cyc("rd_drain1", Drain, 4'b0, 1'b0);
    RST = 1'b1;
    cyc("rd_rst", Rsto, 4'b0, 1'b0);
    RST = 1'b0;
    cyc("rd_rst_post", Rsto, 4'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc($sformatf("rd_run%0d", i), Norm, 4'b0, 1'b0);

    @(negedge CLK);
    #1;
    check_eq("queue_empty", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
